rr_arb_4_enc: RTL and testbench
===============================

Name: rr_arb_4_enc

Overview:
- 4-requester round-robin arbiter that produces a registered 2-bit grant index plus a grant-valid flag.
- It sits directly upstream of the 2-to-4 decoder: grant_idx drives the decoder's A input and grant_valid drives its en input. The decoder output is then the one-hot grant bus to the requesters.
- Grants are held while the owner keeps requesting, up to a programmable maximum, then pre-empted.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held before pre-emption. Legal range 1..255. Counter width is 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  request vector; req[i] high means requester i wants the resource
- grant_idx  output  2  index of the current owner (registered); feeds decoder A
- grant_valid  output  1  a grant is active (registered); feeds decoder en
- grant_new  output  1  one-cycle pulse in the first cycle of every new grant, including a re-grant to the same index

Behaviour:
- Reset (async, immediate):
  - state=IDLE, grant_valid=0, grant_idx=0, grant_new=0, hold_cnt=0.
  - last_ptr=3, so requester 0 has highest priority after reset.
- Arbitration function (combinational): scan req starting at (last_ptr+1) mod 4, ascending with wrap-around. The first set bit wins.
- State IDLE:
  - If req==0: remain in IDLE; outputs unchanged (grant_valid=0).
  - If req!=0 in cycle t: at edge t+1 go to GRANT with grant_idx=winner, grant_valid=1, grant_new=1, hold_cnt=1, last_ptr=winner. One-cycle latency from request to grant.
- State GRANT, evaluated each cycle:
  - release = req[grant_idx]==0.
  - timeout = hold_cnt==MAX_HOLD (with the feature disabled, or lock low).
  - Neither release nor timeout: stay; hold_cnt+1 (saturating at 255); grant_new=0.
  - Release or timeout, with some req bit still set after scanning from grant_idx+1: at the next edge switch directly to the winner with grant_new=1 and hold_cnt=1. This gives back-to-back grants with no idle bubble.
    - The current owner has the lowest priority. It is re-granted only if it is the sole requester on a timeout; grant_new pulses and hold_cnt restarts at 1.
  - Release or timeout with no eligible request: go to IDLE, grant_valid=0, grant_idx holds its last value, grant_new=0.
- A grant therefore lasts at most MAX_HOLD cycles (grant_valid high with the same grant_idx).
- A requester whose req drops during its grant loses the grant at the next edge. A single req-low cycle is sufficient.
- grant_idx never changes while grant_valid=1 except at a grant_new edge.
- MAX_HOLD=1 means a new arbitration every cycle: pure rotation among active requesters.
- Reset asserted mid-grant: grant_valid drops immediately (async) and priority returns to requester 0.

Optional Feature:
- Macro RR_ARB_LOCK_EN.
- Defined:
  - Extra input port lock (1 bit).
  - While lock=1 in GRANT, timeout is suppressed, so the owner keeps the grant until it deasserts req; hold_cnt still saturates.
  - lock is ignored in IDLE and for release.
  - Deasserting lock when hold_cnt>=MAX_HOLD causes pre-emption at the next edge if others request.
- Not defined: no lock port; timeout always applies.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> grant_valid=0, grant_idx=0, grant_new never pulses.
- req=4'b1111 held, MAX_HOLD=2 -> grants rotate idx 0,0,1,1,2,2,3,3,0 with grant_new on each index change, and no bubble between grants.
- req=4'b0100 for 3 cycles, then 4'b0000 -> grant_valid rises 1 cycle after req with idx=2, stays 3 cycles, then returns to 0 one cycle after the drop.
- req=4'b0001 held with MAX_HOLD=8 -> idx 0 re-granted every 8 cycles, with grant_new pulsing each 8th cycle and grant_valid never dropping.
- Owner idx 1 granted, req changes 4'b0010 -> 4'b1001 -> next grant idx=3 (scan from 2), then idx 0 after idx 3 releases.
- RR_ARB_LOCK_EN defined, lock=1, req=4'b0011, MAX_HOLD=2 -> idx 0 held 6 cycles. Lock drops -> idx 1 granted next edge.
- Assert rst mid-grant on idx 3 -> grant_valid=0 immediately. After release with req=4'b1001 -> idx 0 granted first.

Source files
------------

// File: rtl/rr_arb_4_enc.sv
// ============================================================================
// Module   : rr_arb_4_enc
// Brief    : 4-way round-robin arbiter with registered grant index, valid and
//            new-grant pulse; grants are pre-empted after MAX_HOLD cycles.
//            Optional macro RR_ARB_LOCK_EN adds a lock input that suppresses
//            the hold-time pre-emption.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_4_enc #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef RR_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       grant_new
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_GRANT    = 1'b1;
    localparam logic [7:0] c_MAX_HOLD = 8'(MAX_HOLD);
    localparam logic [7:0] c_CNT_SAT  = 8'hFF;

    logic [0:0] r_state;
    logic [1:0] r_grant_idx;
    logic       r_grant_valid;
    logic       r_grant_new;
    logic [7:0] r_hold_cnt;
    logic [1:0] r_last_ptr;

    logic [1:0] w_base;
    logic [1:0] w_win;
    logic       w_found;
    logic       w_release;
    logic       w_timeout;
    logic       w_lock;

`ifdef RR_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // The scan starts one past the current owner, so the owner is visited last
    // and only wins when nobody else is requesting.
    always_comb begin
        logic [1:0] v_cand;
        w_base  = (r_state == c_GRANT) ? r_grant_idx : r_last_ptr;
        w_win   = 2'd0;
        w_found = 1'b0;
        v_cand  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            v_cand = w_base + 2'(i + 1);
            if (!w_found && req[v_cand]) begin
                w_win   = v_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_release = ~req[r_grant_idx];
    // ">=" so that dropping lock after an overlong hold pre-empts immediately
    assign w_timeout = (r_hold_cnt >= c_MAX_HOLD) && !w_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_grant_idx   <= 2'd0;
            r_grant_valid <= 1'b0;
            r_grant_new   <= 1'b0;
            r_hold_cnt    <= 8'd0;
            r_last_ptr    <= 2'd3;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_grant_new <= 1'b0;
                    if (w_found) begin
                        r_state       <= c_GRANT;
                        r_grant_idx   <= w_win;
                        r_grant_valid <= 1'b1;
                        r_grant_new   <= 1'b1;
                        r_hold_cnt    <= 8'd1;
                        r_last_ptr    <= w_win;
                    end
                end
                default: begin
                    if (!w_release && !w_timeout) begin
                        r_grant_new <= 1'b0;
                        if (r_hold_cnt != c_CNT_SAT) begin
                            r_hold_cnt <= r_hold_cnt + 8'd1;
                        end
                    end else if (w_found) begin
                        r_grant_idx <= w_win;
                        r_grant_new <= 1'b1;
                        r_hold_cnt  <= 8'd1;
                        r_last_ptr  <= w_win;
                    end else begin
                        r_state       <= c_IDLE;
                        r_grant_valid <= 1'b0;
                        r_grant_new   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign grant_new   = r_grant_new;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_4_enc.sv
// ============================================================================
// Module   : tb_rr_arb_4_enc
// Brief    : Directed self-checking bench for rr_arb_4_enc (MAX_HOLD 2 and 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arb_4_enc;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       lock;

    logic [1:0] idx2, idx8;
    logic       gv2, gv8;
    logic       gn2, gn8;

    int chk_total = 0;
    int chk_pass  = 0;

    rr_arb_4_enc #(.MAX_HOLD(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
`ifdef RR_ARB_LOCK_EN
        .lock       (lock),
`endif
        .grant_idx  (idx2),
        .grant_valid(gv2),
        .grant_new  (gn2)
    );

    rr_arb_4_enc #(.MAX_HOLD(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
`ifdef RR_ARB_LOCK_EN
        .lock       (1'b0),
`endif
        .grant_idx  (idx8),
        .grant_valid(gv8),
        .grant_new  (gn8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_total++;
        if (obs === exp) chk_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] rot_idx [9];
        logic       rot_new [9];
        rot_idx = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        rot_new = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        req  = 4'b0000;
        lock = 1'b0;
        rst  = 1'b0;
        #2;
        do_reset();
        check("reset_gv", 32'(gv2), 32'd0);
        check("reset_idx", 32'(idx2), 32'd0);
        check("reset_new", 32'(gn2), 32'd0);

        // Idle with no requests
        for (int k = 0; k < 5; k++) begin
            tick();
            check("idle_gv", 32'(gv2), 32'd0);
            check("idle_idx", 32'(idx2), 32'd0);
            check("idle_new", 32'(gn2), 32'd0);
        end

        // Full rotation with MAX_HOLD=2
        req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("rot_gv", 32'(gv2), 32'd1);
            check("rot_idx", 32'(idx2), 32'(rot_idx[k]));
            check("rot_new", 32'(gn2), 32'(rot_new[k]));
        end

        // Single requester 2 for three cycles then drop
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("r2_gv", 32'(gv8), 32'd1);
            check("r2_idx", 32'(idx8), 32'd2);
            check("r2_new", 32'(gn8), (k == 0) ? 32'd1 : 32'd0);
        end
        req = 4'b0000;
        tick();
        check("r2_drop_gv", 32'(gv8), 32'd0);
        check("r2_drop_idx", 32'(idx8), 32'd2);
        check("r2_drop_new", 32'(gn8), 32'd0);

        // Sole requester 0 re-granted every 8 cycles
        do_reset();
        req = 4'b0001;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check("hold_gv", 32'(gv8), 32'd1);
            check("hold_idx", 32'(idx8), 32'd0);
            check("hold_new", 32'(gn8), (k == 1 || k == 9 || k == 17) ? 32'd1 : 32'd0);
        end

        // Owner 1 releases, scan from 2 picks 3, then 0
        req = 4'b0000;
        do_reset();
        req = 4'b0010;
        tick();
        check("sw_idx1", 32'(idx8), 32'd1);
        req = 4'b1001;
        tick();
        check("sw_idx3", 32'(idx8), 32'd3);
        check("sw_new3", 32'(gn8), 32'd1);
        req = 4'b0001;
        tick();
        check("sw_idx0", 32'(idx8), 32'd0);
        check("sw_new0", 32'(gn8), 32'd1);
        check("sw_gv0", 32'(gv8), 32'd1);

        // Asynchronous reset mid-grant on index 3
        req = 4'b0000;
        do_reset();
        req = 4'b1000;
        tick();
        check("ar_pre_idx", 32'(idx8), 32'd3);
        check("ar_pre_gv", 32'(gv8), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_gv", 32'(gv8), 32'd0);
        check("ar_idx", 32'(idx8), 32'd0);
        req = 4'b1001;
        #1;
        rst = 1'b0;
        tick();
        check("ar_post_idx", 32'(idx8), 32'd0);
        check("ar_post_new", 32'(gn8), 32'd1);

`ifdef RR_ARB_LOCK_EN
        // Lock holds owner 0 past MAX_HOLD=2
        req = 4'b0000;
        do_reset();
        lock = 1'b1;
        req  = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("lk_idx", 32'(idx2), 32'd0);
            check("lk_new", 32'(gn2), (k == 0) ? 32'd1 : 32'd0);
        end
        lock = 1'b0;
        tick();
        check("lk_rel_idx", 32'(idx2), 32'd1);
        check("lk_rel_new", 32'(gn2), 32'd1);
`endif

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule

`default_nettype wire
